// File: rtl/vga_timing_pattern_if.sv
// Video-side bundle of vga_timing_pattern: run/pattern controls in, syncs, coordinates and RGB out.
interface vga_timing_pattern_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int COLOR_W = 8
);
  logic               enable;
  logic [1:0]         pattern_sel;
  logic               hsyncs;
  logic               vsync;
  logic               de;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic               frame_start;
  logic [COLOR_W-1:0] R;
  logic [COLOR_W-1:0] G;
  logic [COLOR_W-1:0] B;

  modport master (
    input  enable, pattern_sel,
    output hsyncs, vsync, de, x, y, frame_start, R, G, B
  );

  modport slave (
    output enable, pattern_sel,
    input  hsyncs, vsync, de, x, y, frame_start, R, G, B
  );
endinterface

// File: rtl/vga_timing_pattern.sv
// Parametrised VGA timing generator with a frame-synchronous test-pattern source.
// Every output is registered on the pixel enable, so pins lag the counters by one pixel.
module vga_timing_pattern #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int CLK_DIV   = 2,
  parameter int COLOR_W   = 8,
  parameter int CHK_SHIFT = 5
) (
  input  logic                clk,
  input  logic                reset,
  vga_timing_pattern_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_W     = $clog2(H_TOTAL);
  localparam int Y_W     = $clog2(V_TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  localparam logic               HS_ACT = (HS_POL != 0);
  localparam logic               VS_ACT = (VS_POL != 0);
  localparam logic [COLOR_W-1:0] FULL   = '1;

  logic [DIV_W-1:0]   div_cnt;
  logic [X_W-1:0]     h_cnt;
  logic [Y_W-1:0]     v_cnt;
  logic [1:0]         pat_q;

  logic               pix_en;
  logic               h_last;
  logic               v_last;
  logic               at_origin;
  logic [31:0]        h32;
  logic [31:0]        v32;
  logic [1:0]         pat_now;

  logic               de_d;
  logic               hs_d;
  logic               vs_d;
  logic [2:0]         bar_rgb;
  logic [COLOR_W-1:0] r_d;
  logic [COLOR_W-1:0] g_d;
  logic [COLOR_W-1:0] b_d;

  assign pix_en    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_last    = (h_cnt == X_W'(H_TOTAL - 1));
  assign v_last    = (v_cnt == Y_W'(V_TOTAL - 1));
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign h32       = 32'(h_cnt);
  assign v32       = 32'(v_cnt);

  // The origin pixel already belongs to the new frame, so it uses the freshly sampled selection.
  assign pat_now = at_origin ? vif.pattern_sel : pat_q;

  always_comb begin
    de_d    = (h32 < 32'(H_ACTIVE)) && (v32 < 32'(V_ACTIVE));
    hs_d    = ((h32 >= 32'(HS_BEG)) && (h32 < 32'(HS_END))) ? HS_ACT : ~HS_ACT;
    vs_d    = ((v32 >= 32'(VS_BEG)) && (v32 < 32'(VS_END))) ? VS_ACT : ~VS_ACT;
    bar_rgb = 3'b000;
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;

    case ((h32 * 32'd8) / 32'(H_ACTIVE))
      32'd0:   bar_rgb = 3'b111;
      32'd1:   bar_rgb = 3'b110;
      32'd2:   bar_rgb = 3'b011;
      32'd3:   bar_rgb = 3'b010;
      32'd4:   bar_rgb = 3'b101;
      32'd5:   bar_rgb = 3'b100;
      32'd6:   bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase

    if (de_d) begin
      case (pat_now)
        2'd1: begin
          r_d = {COLOR_W{bar_rgb[2]}};
          g_d = {COLOR_W{bar_rgb[1]}};
          b_d = {COLOR_W{bar_rgb[0]}};
        end
        2'd2: begin
          if ((((h32 >> CHK_SHIFT) ^ (v32 >> CHK_SHIFT)) & 32'd1) != 32'd0) begin
            r_d = FULL;
            g_d = FULL;
            b_d = FULL;
          end
        end
        2'd3: begin
          r_d = COLOR_W'(h32);
          g_d = COLOR_W'(v32);
          b_d = COLOR_W'(h32 + v32);
        end
        default: begin
          r_d = '0;
          g_d = '0;
          b_d = '0;
        end
      endcase
    end
  end

  // Hold takes priority over a coincident pixel enable, leaving the outputs idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt         <= '0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      pat_q           <= 2'd0;
      vif.de          <= 1'b0;
      vif.hsyncs      <= ~HS_ACT;
      vif.vsync       <= ~VS_ACT;
      vif.x           <= '0;
      vif.y           <= '0;
      vif.frame_start <= 1'b0;
      vif.R           <= '0;
      vif.G           <= '0;
      vif.B           <= '0;
    end else if (!vif.enable) begin
      div_cnt         <= '0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      vif.de          <= 1'b0;
      vif.hsyncs      <= ~HS_ACT;
      vif.vsync       <= ~VS_ACT;
      vif.x           <= '0;
      vif.y           <= '0;
      vif.frame_start <= 1'b0;
      vif.R           <= '0;
      vif.G           <= '0;
      vif.B           <= '0;
    end else begin
      div_cnt <= pix_en ? '0 : div_cnt + DIV_W'(1);
      if (pix_en) begin
        h_cnt <= h_last ? '0 : h_cnt + X_W'(1);
        if (h_last) begin
          v_cnt <= v_last ? '0 : v_cnt + Y_W'(1);
        end
        if (at_origin) begin
          pat_q <= vif.pattern_sel;
        end
        vif.de          <= de_d;
        vif.hsyncs      <= hs_d;
        vif.vsync       <= vs_d;
        vif.x           <= h_cnt;
        vif.y           <= v_cnt;
        vif.frame_start <= at_origin;
        vif.R           <= r_d;
        vif.G           <= g_d;
        vif.B           <= b_d;
      end
    end
  end
endmodule
